ps2_device_tx: RTL and testbench

- Device-side PS/2 transmitter. It emulates a keyboard or mouse toward a PS/2 host port, such as the system's ps2_key / ps2_mouse interfaces.
- It generates the PS/2 clock itself, serialises one byte per 11-bit frame (start, 8 data LSB-first, odd parity, stop), and drives both lines open-drain.
- It detects host inhibit and host request-to-send. Used in board-level loopback rigs and the host-interface regression bench.

---
 rtl/ps2_device_tx.sv | 137 +++++++++++++
 tb/tb_ps2_device_tx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: generates the PS/2 clock, shifts out one
// 11-bit frame (start, 8 data LSB-first, odd parity, stop) open-drain, and
// backs off on host inhibit / reports host request-to-send while idle.
module ps2_device_tx #(
  parameter int HALF_PERIOD = 2500,
  parameter int IDLE_CYCLES = 2500
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_aborted,
  output logic       busy,
  output logic       host_rts,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int MAXP = (HALF_PERIOD > IDLE_CYCLES) ? HALF_PERIOD : IDLE_CYCLES;
  localparam int CW   = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] LOW_LAST  = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] QTR_LAST  = CW'(HALF_PERIOD / 2 - 1);
  localparam logic [CW-1:0] IDLE_MAX  = CW'(IDLE_CYCLES);
  // Phase count below which a low clock is still our own release settling.
  localparam logic [CW-1:0] GUARD     = CW'(4);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_LOW, S_HIGH} state_t;

  state_t          state, state_nxt;
  logic            clk_meta, clk_s, dat_meta, dat_s;
  logic [CW-1:0]   phase, idle_cnt;
  logic [3:0]      bit_idx;
  logic [7:0]      data_q;
  logic            parity_q;
  logic            done_q, abort_q;

  logic            ready, accept, inhibit, frame_end;
  logic [10:0]     frame;

  assign ready  = (state == S_IDLE) && (idle_cnt == IDLE_MAX);
  assign accept = ready && tx_valid;
  assign frame  = {1'b1, parity_q, data_q, 1'b0};

  // State register plus synchronisers, phase/idle counters and byte latch
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      clk_meta <= 1'b0;
      clk_s    <= 1'b0;
      dat_meta <= 1'b0;
      dat_s    <= 1'b0;
      phase    <= '0;
      idle_cnt <= '0;
      bit_idx  <= '0;
      data_q   <= '0;
      parity_q <= 1'b0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      clk_meta <= ps2_clk_in;
      clk_s    <= clk_meta;
      dat_meta <= ps2_dat_in;
      dat_s    <= dat_meta;
      state    <= state_nxt;

      if (state == S_IDLE || state_nxt != state) phase <= '0;
      else                                       phase <= phase + 1'b1;

      // Idle qualification only counts in IDLE; any frame activity clears it.
      if (state != S_IDLE || accept)   idle_cnt <= '0;
      else if (clk_s && dat_s) begin
        if (idle_cnt != IDLE_MAX)      idle_cnt <= idle_cnt + 1'b1;
      end else                         idle_cnt <= '0;

      if (accept) begin
        data_q   <= tx_data;
        parity_q <= ~^tx_data;
        bit_idx  <= '0;
      end else if (state == S_HIGH && state_nxt == S_SETUP) begin
        bit_idx  <= bit_idx + 1'b1;
      end

      done_q  <= frame_end;
      abort_q <= inhibit;
    end
  end

  // Next-state: slot sequencing, inhibit takes priority over slot end
  always_comb begin
    state_nxt = state;
    inhibit   = 1'b0;
    frame_end = 1'b0;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_SETUP;
      S_SETUP: begin
        if (phase >= GUARD && !clk_s) begin
          inhibit   = 1'b1;
          state_nxt = S_IDLE;
        end else if (phase == QTR_LAST) begin
          state_nxt = S_LOW;
        end
      end
      S_LOW:   if (phase == LOW_LAST) state_nxt = S_HIGH;
      S_HIGH: begin
        if (phase >= GUARD && !clk_s) begin
          inhibit   = 1'b1;
          state_nxt = S_IDLE;
        end else if (phase == QTR_LAST) begin
          if (bit_idx == 4'd10) begin
            frame_end = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_SETUP;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs: line drivers follow state, pulses come from registered events
  always_comb begin
    busy       = (state != S_IDLE);
    tx_ready   = ready;
    tx_done    = done_q;
    tx_aborted = abort_q;
    host_rts   = (state == S_IDLE) && clk_s && !dat_s;
    ps2_clk_oe = (state == S_LOW);
    ps2_dat_oe = (state != S_IDLE) && !frame[bit_idx];
  end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Directed bench for ps2_device_tx with pull-up + open-drain line model.
module tb_ps2_device_tx;

  localparam int HP = 20;
  localparam int IC = 40;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_valid = 1'b0;
  logic tx_ready, tx_done, tx_aborted, busy, host_rts;
  logic ps2_clk_oe, ps2_dat_oe;
  logic host_clk_low = 1'b0, host_dat_low = 1'b0;
  logic ps2_clk_line, ps2_dat_line;

  assign ps2_clk_line = ~(ps2_clk_oe | host_clk_low);
  assign ps2_dat_line = ~(ps2_dat_oe | host_dat_low);

  ps2_device_tx #(.HALF_PERIOD(HP), .IDLE_CYCLES(IC)) dut (
    .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_aborted(tx_aborted),
    .busy(busy), .host_rts(host_rts),
    .ps2_clk_in(ps2_clk_line), .ps2_dat_in(ps2_dat_line),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int abort_cnt = 0;

  always @(posedge clk) begin
    if (tx_done)    done_cnt  <= done_cnt + 1;
    if (tx_aborted) abort_cnt <= abort_cnt + 1;
  end

  // Host-side sampler: data is read on every falling edge of the clock line
  bit     cap_en = 1'b0;
  logic   samp_q[$];
  longint fall_t[$];
  always @(negedge ps2_clk_line) begin
    if (cap_en) begin
      samp_q.push_back(ps2_dat_line);
      fall_t.push_back(longint'($time));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] frame_at(input int base);
    logic [10:0] v;
    v = '0;
    for (int i = 0; i < 11; i++)
      v[i] = (base + i < samp_q.size()) ? samp_q[base + i] : 1'bx;
    return v;
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!tx_ready && n < 200) begin
      tick();
      n++;
    end
    chk(tag, tx_ready, 1'b1);
  endtask

  // Lines released after edge R: syncs settle at R+2, counter hits IC at R+42.
  task automatic ready_timing(input string tag);
    for (int i = 0; i < 41; i++) tick();
    chk({tag, "_early"}, tx_ready, 1'b0);
    tick();
    chk({tag, "_rise"}, tx_ready, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 1000) begin
      tick();
      n++;
    end
    chk(tag, busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    longint t_acc;
    int n, d0, a0, seen;
    logic [1:0] oe_at_abort;
    logic       busy_at_abort;

    // ---- reset release with lines high
    repeat (3) tick();
    chk("rst_outs", {tx_ready, tx_done, tx_aborted, busy, host_rts, ps2_clk_oe, ps2_dat_oe}, 7'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 41; i++) begin
      tick();
      chk("rst_quiet", {tx_ready, tx_done, tx_aborted, busy, host_rts, ps2_clk_oe, ps2_dat_oe}, 7'd0);
    end
    tick();
    chk("rst_ready", {tx_ready, tx_done, tx_aborted, busy, host_rts, ps2_clk_oe, ps2_dat_oe}, 7'b1000000);

    // ---- send 0x1C
    samp_q.delete(); fall_t.delete(); cap_en = 1'b1;
    tx_data = 8'h1C; tx_valid = 1'b1;
    tick();
    t_acc = longint'($time) - 1;
    tx_valid = 1'b0;
    chk("acc_busy", {busy, tx_ready}, 2'b10);
    n = 1;
    for (int i = 0; i < 1000 && busy; i++) begin
      tick();
      if (busy) n++;
    end
    chk("busy_len", n, 440);
    chk("done_pulse", tx_done, 1'b1);
    chk("lines_rel", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    tick();
    chk("done_once", tx_done, 1'b0);
    chk("nbits_1c", samp_q.size(), 11);
    chk("frame_1c", frame_at(0), 11'b10000111000);
    chk("first_fall", (fall_t.size() > 0) ? 32'((fall_t[0] - t_acc) / 10) : 32'hFFFF, 10);
    chk("clk_period", (fall_t.size() > 1) ? 32'((fall_t[1] - fall_t[0]) / 10) : 32'hFFFF, 40);

    // ---- back-to-back 0x00 then 0xFF, tx_valid held
    wait_ready("b2b_rdy");
    samp_q.delete(); fall_t.delete();
    tx_data = 8'h00; tx_valid = 1'b1;
    tick();
    chk("b2b_acc1", busy, 1'b1);
    tx_data = 8'hFF;
    wait_idle("b2b_done1");
    chk("b2b_done1p", tx_done, 1'b1);
    n = 0;
    while (!busy && n < 200) begin
      tick();
      n++;
    end
    tx_valid = 1'b0;
    chk("b2b_gap", (n >= 40) ? 1 : 0, 1);
    wait_idle("b2b_done2");
    chk("b2b_done2p", tx_done, 1'b1);
    chk("nbits_b2b", samp_q.size(), 22);
    chk("frame_00", frame_at(0), 11'b11000000000);
    chk("frame_ff", frame_at(11), 11'b11111111110);

    // ---- host inhibit in HIGH phase of bit 4
    wait_ready("inh_rdy");
    samp_q.delete(); fall_t.delete();
    d0 = done_cnt; a0 = abort_cnt;
    tx_data = 8'hA5; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    n = 0;
    while (!(samp_q.size() >= 5 && !ps2_clk_oe) && n < 1000) begin
      tick();
      n++;
    end
    chk("inh_reach", samp_q.size(), 5);
    repeat (3) tick();
    cap_en = 1'b0;
    host_clk_low = 1'b1;
    seen = 0; oe_at_abort = 2'b11; busy_at_abort = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n++;
      if (tx_aborted) begin
        seen = 1;
        oe_at_abort = {ps2_clk_oe, ps2_dat_oe};
        busy_at_abort = busy;
        break;
      end
    end
    chk("inh_abort", seen, 1);
    chk("inh_oe", oe_at_abort, 2'b00);
    chk("inh_busy", busy_at_abort, 1'b0);
    while (n < 200) begin
      tick();
      n++;
    end
    chk("inh_abort_cnt", abort_cnt - a0, 1);
    chk("inh_no_done", done_cnt - d0, 0);
    chk("inh_rdy_held", tx_ready, 1'b0);
    host_clk_low = 1'b0;
    ready_timing("inh");

    // ---- host request-to-send: data low, clock high
    host_dat_low = 1'b1;
    tick(); tick();
    chk("rts_on", host_rts, 1'b1);
    tick();
    chk("rts_notready", tx_ready, 1'b0);
    tx_data = 8'h33; tx_valid = 1'b1;
    repeat (5) tick();
    chk("rts_ignored", {busy, ps2_clk_oe, ps2_dat_oe}, 3'b000);
    tx_valid = 1'b0;
    host_dat_low = 1'b0;
    tick(); tick();
    chk("rts_off", host_rts, 1'b0);
    for (int i = 0; i < 39; i++) tick();
    chk("rts_early", tx_ready, 1'b0);
    tick();
    chk("rts_rise", tx_ready, 1'b1);

    // ---- reset in the middle of a frame (bit 6)
    samp_q.delete(); fall_t.delete(); cap_en = 1'b1;
    d0 = done_cnt; a0 = abort_cnt;
    tx_data = 8'h55; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    n = 0;
    while (samp_q.size() < 7 && n < 1000) begin
      tick();
      n++;
    end
    chk("mrst_reach", busy, 1'b1);
    reset_n = 1'b0;
    tick();
    chk("mrst_outs", {ps2_clk_oe, ps2_dat_oe, busy, tx_done, tx_aborted}, 5'd0);
    cap_en = 1'b0;
    reset_n = 1'b1;
    ready_timing("mrst");
    chk("mrst_no_pulse", (done_cnt - d0) + (abort_cnt - a0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
